sram_req_sequencer: RTL and testbench

Request front-end placed directly upstream of the SRAM core. It buffers host read/write commands in a small FIFO and issues them one at a time on the core's enable / read_not_write / ready interface, holding address and data stable until the core completes. It returns read data through a valid/ready response port and guards each operation with a timeout.

---
 rtl/sram_req_sequencer.sv | 107 ++++++++++
 tb/tb_sram_req_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_sequencer.sv
// sram_req_sequencer: FIFO-buffered command issuer for the SRAM core with read responses and per-op timeout
module sram_req_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [9:0] req_addr,
  input  logic [3:0] req_wdata,
  input  logic       req_rnw,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_rdata,
  output logic       rsp_err,
  output logic [9:0] mem_addr,
  output logic [3:0] mem_data_in,
  output logic       mem_enable,
  output logic       mem_read_not_write,
  input  logic [3:0] mem_data_out,
  input  logic       mem_ready,
  output logic       busy,
  output logic       err_sticky
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  logic [14:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  state_t        r_state;
  logic [CW-1:0] r_tcnt;
  logic [9:0]    r_mem_addr;
  logic [3:0]    r_mem_data_in, r_rsp_rdata;
  logic          r_mem_enable, r_mem_rnw, r_rsp_valid, r_rsp_err, r_err_sticky;
  logic [14:0]   w_head;
  logic          w_full, w_push, w_pop, w_tout;
  assign w_head = r_fifo[r_rp];
  assign w_full = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign w_push = req_valid && !w_full;
  // a read waits while an earlier read response is still unclaimed
  assign w_pop  = r_state == IDLE && r_cnt != '0 && !(w_head[0] && r_rsp_valid);
  assign w_tout = r_tcnt == CW'(TIMEOUT_CYCLES - 1);
  assign req_ready          = !rst && !w_full;
  assign busy               = !rst && (r_cnt != '0 || r_state != IDLE);
  assign rsp_valid          = r_rsp_valid;
  assign rsp_rdata          = r_rsp_rdata;
  assign rsp_err            = r_rsp_err;
  assign mem_addr           = r_mem_addr;
  assign mem_data_in        = r_mem_data_in;
  assign mem_enable         = r_mem_enable;
  assign mem_read_not_write = r_mem_rnw;
  assign err_sticky         = r_err_sticky;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= {req_addr, req_wdata, req_rnw};
        r_wp         <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_tcnt        <= '0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
      r_mem_enable  <= 1'b0;
      r_mem_rnw     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_err_sticky  <= 1'b0;
    end else begin
      if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_pop) begin
          r_state       <= ISSUE;
          r_tcnt        <= '0;
          r_mem_enable  <= 1'b1;
          r_mem_addr    <= w_head[14:5];
          r_mem_data_in <= w_head[0] ? 4'b0 : w_head[4:1];
          r_mem_rnw     <= w_head[0];
        end
        ISSUE: if (mem_ready || w_tout) begin
          r_state      <= GAP;
          r_mem_enable <= 1'b0;
          if (!mem_ready) r_err_sticky <= 1'b1;
          if (r_mem_rnw) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= mem_ready ? mem_data_out : 4'b0;
            r_rsp_err   <= !mem_ready;
          end
        end else r_tcnt <= r_tcnt + 1'b1;
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_req_sequencer.sv
// tb_sram_req_sequencer: directed stimulus, cycle model of the sequencer and a behavioural SRAM core
module tb_sram_req_sequencer;
  localparam int T = 15;
  localparam int D = 4;
  typedef struct packed {logic [9:0] addr; logic [3:0] wdata; logic rnw;} cmd_t;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_rnw = 1'b0, rsp_ready = 1'b1, mem_ready = 1'b0;
  logic [9:0] req_addr = '0;
  logic [3:0] req_wdata = '0, mem_data_out = '0;
  logic req_ready, rsp_valid, rsp_err, mem_enable, mem_read_not_write, busy, err_sticky;
  logic [3:0] rsp_rdata, mem_data_in;
  logic [9:0] mem_addr;
  int checks = 0, errors = 0;
  sram_req_sequencer #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rnw(req_rnw), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_enable(mem_enable), .mem_read_not_write(mem_read_not_write), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .busy(busy), .err_sticky(err_sticky));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // SRAM core: ready on the (lat+1)-th enabled cycle, never for a read of 0x155
  logic [3:0] cmem [1024];
  int lat = 2, ecnt = 0;
  bit stray = 0;
  initial for (int a = 0; a < 1024; a++) cmem[a] = 4'(a) + 4'(a >> 4);
  initial forever begin
    @(negedge clk);
    ecnt = mem_enable ? ecnt + 1 : 0;
    mem_ready = mem_enable ? (ecnt == lat + 1 && !(mem_read_not_write && mem_addr == 10'h155)) : stray;
    mem_data_out = 4'($urandom);
    if (mem_enable && mem_ready) begin
      if (mem_read_not_write) mem_data_out = cmem[mem_addr];
      else cmem[mem_addr] = mem_data_in;
    end
  end
  // reference model: queue of commands plus the position within the current operation
  cmd_t m_q[$];
  cmd_t m_cur, m_new;
  int m_stage = 0, m_age = 0;
  bit m_push, m_had_rv;
  logic e_en = 0, e_rnw = 0, e_rv = 0, e_rerr = 0, e_sticky = 0;
  logic [9:0] e_addr = '0;
  logic [3:0] e_din = '0, e_rd = '0;
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_stage = 0; m_age = 0;
      e_en = 0; e_rnw = 0; e_rv = 0; e_rerr = 0; e_sticky = 0; e_addr = '0; e_din = '0; e_rd = '0;
    end else begin
      m_push = req_valid && m_q.size() < D;
      m_new = {req_addr, req_wdata, req_rnw};
      m_had_rv = e_rv;
      if (e_rv && rsp_ready) e_rv = 0;
      if (m_stage == 0) begin
        if (m_q.size() > 0 && !(m_q[0].rnw && m_had_rv)) begin
          m_cur = m_q.pop_front();
          m_stage = 1; m_age = 0;
          e_en = 1; e_addr = m_cur.addr; e_rnw = m_cur.rnw; e_din = m_cur.rnw ? 4'h0 : m_cur.wdata;
        end
      end else if (m_stage == 1) begin
        if (mem_ready || m_age == T - 1) begin
          m_stage = 2; e_en = 0;
          if (!mem_ready) e_sticky = 1;
          if (m_cur.rnw) begin
            e_rv = 1; e_rd = mem_ready ? mem_data_out : 4'h0; e_rerr = !mem_ready;
          end
        end else m_age++;
      end else m_stage = 0;
      if (m_push) m_q.push_back(m_new);
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    chk("req_ready", req_ready, !rst && m_q.size() < D);
    chk("busy", busy, !rst && (m_q.size() > 0 || m_stage != 0));
    chk("mem_enable", mem_enable, e_en);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_data_in", mem_data_in, e_din);
    chk("mem_rnw", mem_read_not_write, e_rnw);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("err_sticky", err_sticky, e_sticky);
    if (e_rv) begin
      chk("rsp_rdata", rsp_rdata, e_rd);
      chk("rsp_err", rsp_err, e_rerr);
    end
  end
  // observed responses and enable-high run lengths
  logic [3:0] got_d[$];
  logic got_e[$];
  int runs[$];
  int run = 0;
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst && rsp_valid && rsp_ready) begin
      got_d.push_back(rsp_rdata);
      got_e.push_back(rsp_err);
    end
    if (mem_enable) run++;
    else begin
      if (run > 0) runs.push_back(run);
      run = 0;
    end
  end
  function automatic logic [3:0] gd(input int i);
    return (i < got_d.size()) ? got_d[i] : 4'bxxxx;
  endfunction
  function automatic logic ge(input int i);
    return (i < got_e.size()) ? got_e[i] : 1'bx;
  endfunction
  function automatic int gr(input int i);
    return (i < runs.size()) ? runs[i] : -1;
  endfunction
  task automatic push(input logic [9:0] a, input logic [3:0] d, input logic rnw);
    int n = 0;
    req_valid = 1; req_addr = a; req_wdata = d; req_rnw = rnw;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin checks++; errors++; $display("FAIL push_wait: req_ready 0 required 1"); end
    @(negedge clk);
    req_valid = 0;
  endtask
  task automatic idle_wait();
    int n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin checks++; errors++; $display("FAIL idle_wait: busy 1 required 0"); end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int n0, r0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n0, r0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_enable", mem_enable, 0);
    // write then read back
    n0 = got_d.size(); r0 = runs.size();
    push(10'h3A5, 4'hC, 0);
    push(10'h3A5, 4'h0, 1);
    idle_wait();
    chk("wr_rd_count", got_d.size() - n0, 1);
    chk("wr_rd_data", gd(n0), 4'hC);
    chk("wr_rd_err", ge(n0), 0);
    chk("wr_rd_ops", runs.size() - r0, 2);
    chk("wr_run_len", gr(r0), 3);
    // back-pressure with response held
    rsp_ready = 0;
    n0 = got_d.size(); r0 = runs.size();
    push(10'h000, 4'h0, 1);
    push(10'h010, 4'h0, 1);
    push(10'h3FF, 4'h0, 1);
    push(10'h20F, 4'h0, 1);
    push(10'h0AA, 4'h0, 1);
    chk("bp_full", req_ready, 0);
    repeat (20) @(negedge clk);
    chk("bp_one_issued", runs.size() - r0, 1);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_data", rsp_rdata, 4'h0);
    chk("bp_busy", busy, 1);
    rsp_ready = 1;
    idle_wait();
    chk("bp_count", got_d.size() - n0, 5);
    chk("bp_d1", gd(n0 + 1), 4'h1);
    chk("bp_d2", gd(n0 + 2), 4'hE);
    chk("bp_d3", gd(n0 + 3), 4'hF);
    chk("bp_d4", gd(n0 + 4), 4'h4);
    // mixed R W W R with the first response held
    rsp_ready = 0;
    n0 = got_d.size(); r0 = runs.size();
    push(10'h010, 4'h0, 1);
    push(10'h050, 4'h7, 0);
    push(10'h060, 4'h9, 0);
    push(10'h050, 4'h0, 1);
    repeat (30) @(negedge clk);
    chk("mix_ops_before_ack", runs.size() - r0, 3);
    chk("mix_rsp_data", rsp_rdata, 4'h1);
    chk("mix_busy_stalled", busy, 1);
    rsp_ready = 1;
    idle_wait();
    chk("mix_count", got_d.size() - n0, 2);
    chk("mix_second", gd(n0 + 1), 4'h7);
    chk("mix_cmem_060", cmem[10'h060], 4'h9);
    // timeout on a read, then a write and read proceed normally
    n0 = got_d.size(); r0 = runs.size();
    push(10'h155, 4'h0, 1);
    push(10'h0AB, 4'h6, 0);
    push(10'h0AB, 4'h0, 1);
    idle_wait();
    chk("to_run_len", gr(r0), T);
    chk("to_next_run_len", gr(r0 + 1), 3);
    chk("to_rdata", gd(n0), 4'h0);
    chk("to_err", ge(n0), 1);
    chk("to_sticky", err_sticky, 1);
    chk("to_after_data", gd(n0 + 1), 4'h6);
    chk("to_after_err", ge(n0 + 1), 0);
    // reset during ISSUE with two commands queued
    lat = 6;
    n0 = got_d.size();
    push(10'h010, 4'h0, 1);
    push(10'h070, 4'h1, 0);
    push(10'h080, 4'h2, 0);
    chk("mr_enable_before", mem_enable, 1);
    rst = 1;
    @(negedge clk);
    chk("mr_enable_after", mem_enable, 0);
    rst = 0;
    @(negedge clk);
    chk("mr_busy", busy, 0);
    chk("mr_req_ready", req_ready, 1);
    chk("mr_sticky", err_sticky, 0);
    repeat (20) @(negedge clk);
    chk("mr_no_rsp", got_d.size() - n0, 0);
    chk("mr_no_write", cmem[10'h070], 4'h7);
    // stray ready pulses while idle and in the gap
    lat = 2;
    stray = 1;
    repeat (5) @(negedge clk);
    chk("stray_idle_busy", busy, 0);
    n0 = got_d.size(); r0 = runs.size();
    push(10'h3FF, 4'h0, 1);
    idle_wait();
    stray = 0;
    repeat (3) @(negedge clk);
    chk("stray_run_len", gr(r0), 3);
    chk("stray_count", got_d.size() - n0, 1);
    chk("stray_data", gd(n0), 4'hE);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
